// File: rtl/cpl_cordic_polar_pkg.sv
// cordic_pkg: full-turn angle constants, arctangent table and width helpers
// shared by the vectoring and rotation CORDICs.
package cordic_pkg;
  localparam logic [31:0] ANG_PI  = 32'h8000_0000;
  localparam logic [31:0] ANG_PI2 = 32'h4000_0000;
  // round(atan(2^-n) / (2*pi) * 2^32)
  localparam logic [31:0] ATAN [32] = '{
    32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756,
    32'd42667331,  32'd21354465,  32'd10679838,  32'd5340245,
    32'd2670163,   32'd1335087,   32'd667544,    32'd333772,
    32'd166886,    32'd83443,     32'd41722,     32'd20861,
    32'd10430,     32'd5215,      32'd2608,      32'd1304,
    32'd652,       32'd326,       32'd163,       32'd81,
    32'd41,        32'd20,        32'd10,        32'd5,
    32'd3,         32'd1,         32'd1,         32'd0
  };
  function automatic int wr(input int iw, input int eb);
    return iw + eb + 2;
  endfunction
  function automatic int stg(input int iw, input int eb);
    return iw + eb - 2;
  endfunction
  function automatic int lat(input int iw, input int eb);
    return stg(iw, eb) + 2;
  endfunction
endpackage

// File: rtl/cpl_cordic_polar_if.sv
// cpl_cordic_polar_if: I/Q sample stream in, magnitude/phase/frequency out.
interface cpl_cordic_polar_if
  import cordic_pkg::*;
#(
  parameter int IN_WIDTH   = 16,
  parameter int EXTRA_BITS = 5
);
  localparam int WR = wr(IN_WIDTH, EXTRA_BITS);
  logic                       in_valid;
  logic signed [IN_WIDTH-1:0] in_data_I;
  logic signed [IN_WIDTH-1:0] in_data_Q;
  logic                       out_valid;
  logic signed [WR-1:0]       out_mag;
  logic        [31:0]         out_phase;
  logic                       freq_valid;
  logic signed [31:0]         out_freq;
  modport master (
    output in_valid, in_data_I, in_data_Q,
    input  out_valid, out_mag, out_phase, freq_valid, out_freq
  );
  modport slave (
    input  in_valid, in_data_I, in_data_Q,
    output out_valid, out_mag, out_phase, freq_valid, out_freq
  );
endinterface

// File: rtl/cpl_cordic_polar_vec_stage.sv
// cordic_vec_stage: one vectoring iteration driving Y towards zero while
// accumulating the rotated angle in Z; valid/zero flags ride alongside.
module cordic_vec_stage
  import cordic_pkg::*;
#(
  parameter int W = 23,
  parameter int N = 0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                i_valid,
  input  logic                i_zero,
  input  logic signed [W-1:0] i_x,
  input  logic signed [W-1:0] i_y,
  input  logic        [31:0]  i_z,
  output logic                o_valid,
  output logic                o_zero,
  output logic signed [W-1:0] o_x,
  output logic signed [W-1:0] o_y,
  output logic        [31:0]  o_z
);
  logic signed [W-1:0] w_xs, w_ys;
  if (N == 0) begin : g_n0
    assign w_xs = i_x;
    assign w_ys = i_y;
  end else begin : g_nr
    // round-half-up of the shifted term using the last bit shifted out
    assign w_xs = (i_x >>> N) + $signed({1'b0, i_x[N-1]});
    assign w_ys = (i_y >>> N) + $signed({1'b0, i_y[N-1]});
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      o_valid <= 1'b0;
      o_zero  <= 1'b0;
      o_x     <= '0;
      o_y     <= '0;
      o_z     <= '0;
    end else begin
      o_valid <= i_valid;
      o_zero  <= i_zero;
      o_x     <= i_y[W-1] ? i_x - w_ys : i_x + w_ys;
      o_y     <= i_y[W-1] ? i_y + w_xs : i_y - w_xs;
      o_z     <= i_y[W-1] ? i_z - ATAN[N] : i_z + ATAN[N];
    end
endmodule

// File: rtl/cpl_cordic_polar.sv
// cpl_cordic_polar: pipelined vectoring CORDIC turning I/Q into magnitude,
// full-turn phase and a phase-difference frequency word.
module cpl_cordic_polar
  import cordic_pkg::*;
#(
  parameter int IN_WIDTH   = 16,
  parameter int EXTRA_BITS = 5
) (
  input logic clock,
  input logic reset_n,
  cpl_cordic_polar_if.slave io
);
  localparam int WR  = wr(IN_WIDTH, EXTRA_BITS);
  localparam int STG = stg(IN_WIDTH, EXTRA_BITS);
  logic signed [WR-1:0] w_ix, w_qx;
  logic                 w_neg;
  logic signed [WR-1:0] r_x, r_y;
  logic        [31:0]   r_z;
  logic                 r_v, r_zr;
  logic signed [WR-1:0] w_x [STG+1];
  logic signed [WR-1:0] w_y [STG+1];
  logic        [31:0]   w_z [STG+1];
  logic        [STG:0]  w_v, w_zr;
  logic        [31:0]   w_phase;
  logic                 w_unused_y;
  logic                 r_ov, r_fv, r_have;
  logic signed [WR-1:0] r_mag;
  logic        [31:0]   r_phase, r_freq;
  assign w_ix  = {{2{io.in_data_I[IN_WIDTH-1]}}, io.in_data_I, {EXTRA_BITS{1'b0}}};
  assign w_qx  = {{2{io.in_data_Q[IN_WIDTH-1]}}, io.in_data_Q, {EXTRA_BITS{1'b0}}};
  assign w_neg = io.in_data_I[IN_WIDTH-1];
  // fold the left half-plane onto the right so the iterations always converge
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_v  <= 1'b0;
      r_zr <= 1'b0;
      r_x  <= '0;
      r_y  <= '0;
      r_z  <= '0;
    end else begin
      r_v  <= io.in_valid;
      r_zr <= (io.in_data_I == '0) && (io.in_data_Q == '0);
      r_x  <= w_neg ? -w_ix : w_ix;
      r_y  <= w_neg ? -w_qx : w_qx;
      r_z  <= w_neg ? ANG_PI : '0;
    end
  assign w_x[0]  = r_x;
  assign w_y[0]  = r_y;
  assign w_z[0]  = r_z;
  assign w_v[0]  = r_v;
  assign w_zr[0] = r_zr;
  for (genvar i = 0; i < STG; i++) begin : g_stg
    cordic_vec_stage #(.W(WR), .N(i)) u_stage (
      .clock   (clock),
      .reset_n (reset_n),
      .i_valid (w_v[i]),
      .i_zero  (w_zr[i]),
      .i_x     (w_x[i]),
      .i_y     (w_y[i]),
      .i_z     (w_z[i]),
      .o_valid (w_v[i+1]),
      .o_zero  (w_zr[i+1]),
      .o_x     (w_x[i+1]),
      .o_y     (w_y[i+1]),
      .o_z     (w_z[i+1])
    );
  end
  assign w_unused_y = ^w_y[STG];
  assign w_phase    = w_zr[STG] ? '0 : w_z[STG];
  // r_phase doubles as the last valid phase for the differentiator
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_ov    <= 1'b0;
      r_fv    <= 1'b0;
      r_have  <= 1'b0;
      r_mag   <= '0;
      r_phase <= '0;
      r_freq  <= '0;
    end else begin
      r_ov <= w_v[STG];
      r_fv <= w_v[STG] & r_have;
      if (w_v[STG]) begin
        r_have  <= 1'b1;
        r_mag   <= w_x[STG];
        r_phase <= w_phase;
        r_freq  <= w_phase - r_phase;
      end
    end
  assign io.out_valid  = r_ov;
  assign io.freq_valid = r_fv;
  assign io.out_mag    = r_mag;
  assign io.out_phase  = r_phase;
  assign io.out_freq   = r_freq;
endmodule

// File: tb/tb_cpl_cordic_polar.sv
// tb_cpl_cordic_polar: directed I/Q vectors with a queue scoreboard checked
// by an independent output monitor.
module tb_cpl_cordic_polar;
  localparam real PI = 3.14159265358979323846;
  localparam real K  = 1.6467602581210656;
  typedef struct {
    int          cyc;
    longint      mag;
    int          mtol;
    logic [31:0] ph;
    int          ptol;
    bit          fv;
    logic [31:0] fq;
  } exp_t;
  logic clock = 1'b0;
  logic reset_n = 1'b1;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int n_ov = 0;
  exp_t sb[$];
  exp_t me;
  bit m_have = 1'b0;
  logic [31:0] m_last = '0;
  cpl_cordic_polar_if #(.IN_WIDTH(16), .EXTRA_BITS(5)) io ();
  cpl_cordic_polar #(.IN_WIDTH(16), .EXTRA_BITS(5)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .io      (io)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  function automatic longint absl(input longint d);
    return d < 0 ? -d : d;
  endfunction
  function automatic longint wdiff(input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] d;
    d = a - b;
    return absl(longint'(d));
  endfunction
  task automatic chk(input string nm, input bit ok, input longint act, input longint exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic send(input int ii, input int qq, input longint m, input int mt,
                      input logic [31:0] ph, input int pt);
    exp_t e;
    @(negedge clock);
    io.in_valid  = 1'b1;
    io.in_data_I = 16'(ii);
    io.in_data_Q = 16'(qq);
    e.cyc  = cyc;
    e.mag  = m;
    e.mtol = mt;
    e.ph   = ph;
    e.ptol = pt;
    e.fv   = m_have;
    e.fq   = ph - m_last;
    m_last = ph;
    m_have = 1'b1;
    sb.push_back(e);
  endtask
  task automatic send_model(input int ii, input int qq);
    longint ph, m;
    ph = longint'($atan2(real'(qq), real'(ii)) / (2.0 * PI) * 4294967296.0);
    m  = longint'($sqrt(real'(ii) * real'(ii) + real'(qq) * real'(qq)) * 32.0 * K);
    send(ii, qq, m, 8, ph[31:0], 16384);
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      io.in_valid = 1'b0;
    end
  endtask
  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_out_valid"}, io.out_valid == 1'b0, io.out_valid, 0);
    chk({tag, "_freq_valid"}, io.freq_valid == 1'b0, io.freq_valid, 0);
    chk({tag, "_out_mag"}, io.out_mag == '0, io.out_mag, 0);
    chk({tag, "_out_phase"}, io.out_phase == '0, io.out_phase, 0);
    chk({tag, "_out_freq"}, io.out_freq == '0, io.out_freq, 0);
  endtask
  always @(negedge clock)
    if (reset_n && io.out_valid) begin
      n_ov++;
      if (sb.size() == 0) chk("unexpected_out", 1'b0, 1, 0);
      else begin
        me = sb.pop_front();
        chk("latency", cyc - me.cyc == 21, cyc - me.cyc, 21);
        chk("mag", absl(longint'(io.out_mag) - me.mag) <= me.mtol, io.out_mag, me.mag);
        chk("phase", wdiff(io.out_phase, me.ph) <= me.ptol, io.out_phase, me.ph);
        chk("freq_valid", io.freq_valid == me.fv, io.freq_valid, me.fv);
        if (me.fv) chk("freq", wdiff(io.out_freq, me.fq) <= 32768, io.out_freq, me.fq);
      end
    end
  initial begin
    logic [31:0] a;
    real th;
    int n0;
    io.in_valid  = 1'b0;
    io.in_data_I = '0;
    io.in_data_Q = '0;
    #1 reset_n = 1'b0;
    #1 chk_zero_outputs("reset");
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b1;
    // four axes, full-scale corner and the origin
    send(16384, 0, 863374, 8, 32'h0000_0000, 16384);
    idle(25);
    send(0, 16384, 863374, 8, 32'h4000_0000, 16384);
    send(-16384, 0, 863374, 8, 32'h8000_0000, 16384);
    idle(2);
    send(0, -16384, 863374, 8, 32'hC000_0000, 16384);
    send(-32768, -32768, 2442000, 2442, 32'hA000_0000, 16384);
    idle(1);
    send(0, 0, 0, 0, 32'h0000_0000, 0);
    idle(3);
    // tone stepping 1/256 turn per valid sample through +-pi with random gaps
    for (int k = 0; k < 32; k++) begin
      a  = 32'h7000_0000 + 32'(k) * 32'h0100_0000;
      th = 2.0 * PI * real'($signed(a)) / 4294967296.0;
      send_model(int'(32000.0 * $cos(th)), int'(32000.0 * $sin(th)));
      idle(int'($urandom_range(2)));
    end
    idle(25);
    // fill the pipeline, then reset mid-stream
    for (int k = 0; k < 25; k++) send(0, 16384, 863374, 8, 32'h4000_0000, 16384);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    io.in_valid = 1'b0;
    sb.delete();
    m_have = 1'b0;
    m_last = '0;
    #1 chk_zero_outputs("midreset");
    @(posedge clock);
    #2 reset_n = 1'b1;
    n0 = n_ov;
    repeat (30) @(negedge clock);
    chk("no_stale_valid", n_ov == n0, n_ov - n0, 0);
    send(16384, 0, 863374, 8, 32'h0000_0000, 16384);
    send(0, 16384, 863374, 8, 32'h4000_0000, 16384);
    idle(1);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clock);
    @(negedge clock);
    chk("drain", sb.size() == 0, sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cpl_cordic_polar.md
# cpl_cordic_polar

Pipelined CORDIC in vectoring mode: converts a stream of complex I/Q samples to magnitude and phase, and differentiates phase into an instantaneous-frequency word. It is the inverse-direction counterpart of the team's rotation-mode NCO/mixer CORDIC. It sits after decimation on the receive path as the AM/FM/phase detector, and uses the same 32-bit full-turn angle convention as the NCO.

## Interface
- `IN_WIDTH`, 16: I/Q input width, signed.
- `EXTRA_BITS`, 5: LSB guard bits appended to the inputs.
- Derived localparams:
  - `WR = IN_WIDTH+EXTRA_BITS+2`: datapath and magnitude width, 23 by default.
  - `STG = IN_WIDTH+EXTRA_BITS-2`: number of iteration stages, 19 by default.
  - `LAT = STG+2`: pipeline latency, 21 by default.
- `clock` in 1: the single clock; all logic on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: the input sample is valid this cycle.
- `in_data_I`, `in_data_Q` in IN_WIDTH: signed input sample.
- `out_valid` out 1: magnitude and phase are valid.
- `out_mag` out WR: unsigned-valued magnitude, carried in a signed register; not gain-compensated.
- `out_phase` out 32: angle, where 2^32 is one full turn and 0x4000_0000 is +π/2.
- `freq_valid` out 1: `out_freq` is valid.
- `out_freq` out 32: phase difference from the previous valid sample, modulo 2^32, read as signed.

## Operation
- **Input extension:** each input is sign-extended by 2 bits and padded with EXTRA_BITS zero LSBs to WR bits.
- **Stage 0 (quadrant fold):**
  - If I<0: X=−I, Y=−Q, Z=0x8000_0000.
  - Otherwise: X=I, Y=Q, Z=0.
  - A `zero` flag is set when I==0 and Q==0.
  - Negating −2^(IN_WIDTH−1) must not overflow; the 2 guard bits guarantee this.
- **Iteration stage n (0..STG−1):**
  - If Y≥0: X += Y>>>n, Y −= X>>>n, Z += ATAN[n].
  - Otherwise: X −= Y>>>n, Y += X>>>n, Z −= ATAN[n].
  - Shifts are arithmetic and use the previous-stage values.
  - Shifted terms are rounded by adding bit n−1 of the unshifted value when n>0.
  - Z arithmetic is 32-bit and wraps.
- **Angle table:** ATAN[n] = round(atan(2^−n)/(2π)·2^32).
  - ATAN[0] = 536870912, ATAN[1] = 316933406, ATAN[2] = 167458907, ATAN[3] = 85004756.
  - Entries that round to 0 are 0.
- **Output register stage:**
  - `out_mag` = final X, scaled by K ≈ 1.64676 and by 2^EXTRA_BITS.
  - `out_phase` = final Z, or 0 if `zero` is set.
  - `out_freq` = `out_phase` minus `last_phase`, 32-bit wrap.
  - `last_phase` updates only on valid samples.
  - `freq_valid` = `out_valid` AND `have_prev`; `have_prev` sets on the first valid output.
- **Valid handling:** `in_valid` and `zero` travel in a LAT-deep shift register.
  - The X/Y/Z datapath is free-running and never stalls.
  - Invalid bubbles pass through without touching `last_phase` or `have_prev`.
  - `out_mag`, `out_phase` and `out_freq` hold their last valid values while `out_valid` is low.
- **Reset:** all valid bits, `have_prev`, `last_phase` and all outputs go to 0 immediately when `reset_n` falls. X/Y/Z pipeline registers need not be reset.

## Timing
- **Latency:** a sample with `in_valid` high at edge k produces `out_valid` high after edge k+LAT, which is edge k+21 by default.
- **Throughput:** one sample per clock; back-to-back valids give back-to-back outputs.
- **First valid output after reset:** `out_valid`=1 and `freq_valid`=0. Every subsequent valid output has `freq_valid`=1.
- **Gaps:** `out_freq` is always the difference to the previous *valid* sample, regardless of gaps between samples.
- **Reset mid-stream:**
  - In-flight samples are discarded; no `out_valid` appears for them after release.
  - The first sample after release behaves as the first after reset.
- **Boundary cases:**
  - Phase wrap through ±π, e.g. 0x7F00_0000 → 0x8100_0000, gives `out_freq` = +0x0200_0000, not a large negative value.
  - Full-scale corner input (−32768, −32768) gives magnitude ≈ 2 442 000, which fits in WR=23 signed bits.

## Structure
- **Package `cordic_pkg`:**
  - 32-bit `ATAN` table, at least 32 entries.
  - Full-turn angle constants: `ANG_PI` = 0x8000_0000, `ANG_PI2` = 0x4000_0000.
  - Width functions for WR, STG and LAT.
  - The package is shared with the rotation CORDIC when that block is refactored.
- **Sub-module `cordic_vec_stage`:** one iteration stage, parameterized by width and shift n, carrying X/Y/Z and the valid/zero bits. The top instantiates it STG times in a generate loop, between the fold stage and the output/differentiator stage.

## Test plan
- (16384, 0) → `out_phase` = 0 ±2^14 and `out_mag` = 863 374 ±8, with `out_valid` exactly 21 cycles after `in_valid`.
- The other three axes, each with `out_mag` as above:
  - (0, 16384) → `out_phase` 0x4000_0000.
  - (−16384, 0) → `out_phase` 0x8000_0000.
  - (0, −16384) → `out_phase` 0xC000_0000.
  - Tolerance ±2^14 in each case.
- Corner (−32768, −32768) → `out_phase` 0xA000_0000 ±2^14 and `out_mag` 2 442 000 ±0.1%, with no overflow. Input (0, 0) → `out_mag` 0 and `out_phase` exactly 0.
- Constant-amplitude tone stepping 0x0100_0000 per valid sample, crossing ±π, with random `in_valid` gaps:
  - Every `out_freq` = 0x0100_0000 ±2^15.
  - `freq_valid` is low only on the first output.
- Pipeline full of valids, then `reset_n` pulsed low for 1 cycle:
  - All outputs are 0 immediately.
  - No stale `out_valid` appears after release.
  - The next sample gives `freq_valid`=0.
- Random I/Q (10^5 samples) compared against a floating-point atan2/hypot model:
  - Phase error ≤ 2^14 LSB.
  - Magnitude error ≤ 8 LSB after K·2^EXTRA_BITS scaling.
  - Sample-count and ordering preserved.
